regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Write-side front end of the integer register file. It merges the in-order pipeline writeback stream and a long-latency unit (mul/div/load-miss) result stream onto the register file's single write port (AD3/WE3/WD3).
- Holds late results in a one-entry skid buffer and guarantees they are eventually written (starvation limit).
- Keeps a per-register busy scoreboard for long-latency destinations, and its registered write outputs double as the bypass source for the decode stage.

Parameters:
- ADDRESS_WIDTH, 5, register index width; the register file has 2**ADDRESS_WIDTH entries.
- DATA_WIDTH, 32, register data width.
- STARVE_LIMIT, 4, consecutive cycles a full buffer may lose arbitration before the pipeline is stalled; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_valid  in  1  pipeline writeback request this cycle.
- pipe_rd  in  ADDRESS_WIDTH  pipeline destination register.
- pipe_data  in  DATA_WIDTH  pipeline result.
- pipe_ready  out  1  pipeline request accepted; pipeline holds its request while low.
- lu_valid  in  1  long-latency result available.
- lu_rd  in  ADDRESS_WIDTH  long-latency destination register.
- lu_data  in  DATA_WIDTH  long-latency result.
- lu_ready  out  1  long-latency result accepted this cycle.
- issue_valid  in  1  long-latency op issuing; marks issue_rd busy.
- issue_rd  in  ADDRESS_WIDTH  destination of the issuing op.
- issue_ready  out  1  issue permitted (no pending write to issue_rd).
- wr_en  out  1  to register file WE3; also bypass valid.
- wr_addr  out  ADDRESS_WIDTH  to AD3; bypass address.
- wr_data  out  DATA_WIDTH  to WD3; bypass data.
- busy  out  2**ADDRESS_WIDTH  scoreboard; bit i set means register i awaits a long-latency result.

Behaviour:
- Reset (async, rst_n=0): buffer empty, starve_cnt=0, busy=0, wr_en=0, wr_addr=0, wr_data=0.
  - Outputs with reset: pipe_ready=1, lu_ready=1, issue_ready=1.
  - An in-flight buffered result is discarded; the long-latency unit is reset by the same rst_n.
- Skid buffer: one entry (buf_rd, buf_data, buf_full). All long-latency results enter through it.
- Arbitration is combinational each cycle. force = buf_full && starve_cnt==STARVE_LIMIT.
  - force=1: grant buffer; pipe_ready=0.
  - else if pipe_valid: grant pipe; pipe_ready=1.
  - else if buf_full: grant buffer; pipe_ready=1.
  - else: no grant; pipe_ready=1.
- lu_ready = !buf_full || buffer granted this cycle. On lu_valid && lu_ready, the buffer loads lu_rd/lu_data and is full next cycle.
  - Simultaneous drain and load: the buffer stays full with the new entry, and starve_cnt clears to 0.
- Write register, 1-cycle latency: at the edge after a grant, wr_addr/wr_data take the granted rd/data.
  - wr_en=1 iff the granted rd != 0; x0 writes are dropped, but a buffer holding x0 still drains.
  - With no grant, wr_en=0 and wr_addr/wr_data hold their values.
  - The register file commits on the following edge; decode bypasses from wr_* during that cycle.
- starve_cnt:
  - increments, saturating at STARVE_LIMIT, on each edge where buf_full and the pipe is granted;
  - clears when the buffer is granted or is empty.
  - Worst-case buffer wait is therefore STARVE_LIMIT+1 cycles.
- Scoreboard:
  - issue_ready = (issue_rd==0) || !busy[issue_rd].
  - On issue_valid && issue_ready && issue_rd!=0, busy[issue_rd] sets at the edge.
  - busy[buf_rd] clears at the edge where the buffer is granted; the same edge raises wr_en.
  - Set and clear of different registers in the same cycle both take effect. The same register cannot coincide, because issue_ready is low while busy.
  - busy[0] is never set.
- Usage rules (verification asserts these):
  - pipe_rd must not be busy when pipe_valid.
  - lu_rd must be busy when lu_valid (unless lu_rd==0).
  - pipe_valid/pipe_rd/pipe_data must stay stable while pipe_ready=0.

Test Plan:
- Reset then idle: after rst_n rises, wr_en=0, busy=0, pipe_ready=lu_ready=issue_ready=1. Assert rst_n low mid-burst with the buffer full → buffer empty, busy=0, and wr_en=0 immediately, without waiting for a clock edge.
- Pipeline only: pipe_valid with rd=5, data 0xDEADBEEF → next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF. rd=0 → wr_en stays 0.
- Long-latency path: issue rd=7 → busy[7]=1 and a re-issue of rd=7 sees issue_ready=0. lu_valid rd=7, data 0x1234 with the pipe idle → buffer loads; next cycle grant; following cycle wr_en=1, wr_addr=7, busy[7]=0.
- Contention: buffer full (rd=9) and pipe_valid continuously with STARVE_LIMIT=4 → pipe wins 4 cycles. In the 5th cycle pipe_ready=0 and the buffer is granted; next cycle wr_addr=9; then the pipe resumes with its held request written unchanged.
- Back-to-back long-latency results: lu_valid held for 3 results with the pipe idle → lu_ready stays 1 via drain-and-load, and three consecutive wr_en pulses carry the results in order.
- Scoreboard concurrency: issue rd=3 in the same cycle the buffer drains rd=4 → busy[3]=1 and busy[4]=0 after the edge.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Write-side front end of the integer register file. It merges the in-order
// pipeline writeback stream with the long-latency (mul/div/load-miss) result
// stream onto the single register-file write port.
//
// Late results always pass through a one-entry skid buffer. A starvation
// counter guarantees that a buffered result is written within STARVE_LIMIT+1
// cycles. A per-register busy scoreboard tracks outstanding long-latency
// destinations. The registered write outputs also serve as the decode-stage
// bypass source.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   pipe_valid/rd/data, pipe_ready pipeline writeback request and accept
//   lu_valid/rd/data, lu_ready     long-latency result and accept
//   issue_valid/rd, issue_ready    long-latency issue (marks rd busy)
//   wr_en/wr_addr/wr_data          register-file write port and bypass
//   busy                           per-register pending-write scoreboard
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pipe_valid,
    input  logic [ADDRESS_WIDTH-1:0]       pipe_rd,
    input  logic [DATA_WIDTH-1:0]          pipe_data,
    output logic                           pipe_ready,
    input  logic                           lu_valid,
    input  logic [ADDRESS_WIDTH-1:0]       lu_rd,
    input  logic [DATA_WIDTH-1:0]          lu_data,
    output logic                           lu_ready,
    input  logic                           issue_valid,
    input  logic [ADDRESS_WIDTH-1:0]       issue_rd,
    output logic                           issue_ready,
    output logic                           wr_en,
    output logic [ADDRESS_WIDTH-1:0]       wr_addr,
    output logic [DATA_WIDTH-1:0]          wr_data,
    output logic [(1<<ADDRESS_WIDTH)-1:0]  busy
);

    localparam int NREGS = 1 << ADDRESS_WIDTH;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDRESS_WIDTH-1:0] X0 = {ADDRESS_WIDTH{1'b0}};
    localparam logic [NREGS-1:0] ONE_HOT0 = {{(NREGS-1){1'b0}}, 1'b1};

    // State
    logic                     buf_full_q,   buf_full_d;
    logic [ADDRESS_WIDTH-1:0] buf_rd_q,     buf_rd_d;
    logic [DATA_WIDTH-1:0]    buf_data_q,   buf_data_d;
    logic [CNT_W-1:0]         starve_cnt_q, starve_cnt_d;
    logic [NREGS-1:0]         busy_q,       busy_d;
    logic                     wr_en_q,      wr_en_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q,    wr_addr_d;
    logic [DATA_WIDTH-1:0]    wr_data_q,    wr_data_d;

    // Combinational decisions
    logic             force_s;
    logic             grant_buf_s;
    logic             grant_pipe_s;
    logic             lu_load_s;
    logic             issue_ready_s;
    logic             issue_fire_s;
    logic [NREGS-1:0] set_mask_s;
    logic [NREGS-1:0] clr_mask_s;

    // Write-port arbitration; a starved buffer preempts the pipeline.
    always_comb begin
        grant_buf_s  = 1'b0;
        grant_pipe_s = 1'b0;
        force_s      = buf_full_q && (starve_cnt_q == STARVE_MAX);
        if (force_s) begin
            grant_buf_s = 1'b1;
        end else if (pipe_valid) begin
            grant_pipe_s = 1'b1;
        end else if (buf_full_q) begin
            grant_buf_s = 1'b1;
        end else begin
            grant_buf_s  = 1'b0;
            grant_pipe_s = 1'b0;
        end
    end

    // Handshake outputs; the buffer accepts a new result while it drains.
    always_comb begin
        pipe_ready    = !force_s;
        lu_ready      = !buf_full_q || grant_buf_s;
        lu_load_s     = lu_valid && lu_ready;
        issue_ready_s = (issue_rd == X0) || !busy_q[issue_rd];
        issue_ready   = issue_ready_s;
        issue_fire_s  = issue_valid && issue_ready_s && (issue_rd != X0);
    end

    // Skid buffer next state; a load wins over a drain in the same cycle.
    always_comb begin
        buf_full_d = buf_full_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        if (lu_load_s) begin
            buf_full_d = 1'b1;
            buf_rd_d   = lu_rd;
            buf_data_d = lu_data;
        end else if (grant_buf_s) begin
            buf_full_d = 1'b0;
        end else begin
            buf_full_d = buf_full_q;
        end
    end

    // Starvation counter: counts pipeline wins over a waiting buffer.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!buf_full_q || grant_buf_s) begin
            starve_cnt_d = {CNT_W{1'b0}};
        end else if (grant_pipe_s && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Write register: x0 grants update address/data but never assert wr_en.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (grant_buf_s) begin
            wr_en_d   = (buf_rd_q != X0);
            wr_addr_d = buf_rd_q;
            wr_data_d = buf_data_q;
        end else if (grant_pipe_s) begin
            wr_en_d   = (pipe_rd != X0);
            wr_addr_d = pipe_rd;
            wr_data_d = pipe_data;
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // Scoreboard: set on issue, clear when the buffered result is granted.
    always_comb begin
        set_mask_s = {NREGS{1'b0}};
        clr_mask_s = {NREGS{1'b0}};
        if (issue_fire_s) begin
            set_mask_s = ONE_HOT0 << issue_rd;
        end else begin
            set_mask_s = {NREGS{1'b0}};
        end
        if (grant_buf_s) begin
            clr_mask_s = ONE_HOT0 << buf_rd_q;
        end else begin
            clr_mask_s = {NREGS{1'b0}};
        end
        busy_d = ((busy_q & ~clr_mask_s) | set_mask_s) & ~ONE_HOT0;
    end

    // State registers with asynchronous reset; reset discards a buffered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full_q   <= 1'b0;
            buf_rd_q     <= {ADDRESS_WIDTH{1'b0}};
            buf_data_q   <= {DATA_WIDTH{1'b0}};
            starve_cnt_q <= {CNT_W{1'b0}};
            busy_q       <= {NREGS{1'b0}};
            wr_en_q      <= 1'b0;
            wr_addr_q    <= {ADDRESS_WIDTH{1'b0}};
            wr_data_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            buf_full_q   <= buf_full_d;
            buf_rd_q     <= buf_rd_d;
            buf_data_q   <= buf_data_d;
            starve_cnt_q <= starve_cnt_d;
            busy_q       <= busy_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_write_arbiter: a table of per-cycle stimulus with
// expected handshake and write results, followed by hand-written sequences for
// scoreboard concurrency, starvation, and asynchronous reset. Expected write
// results are queued when stimulus is driven and compared after the edge.
// -----------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid, lu_valid, issue_valid;
    logic [4:0]  pipe_rd, lu_rd, issue_rd;
    logic [31:0] pipe_data, lu_data;
    logic        pipe_ready, lu_ready, issue_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] busy;

    int checks   = 0;
    int failures = 0;

    regfile_write_arbiter #(
        .ADDRESS_WIDTH(5), .DATA_WIDTH(32), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .pipe_ready(pipe_ready),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pdata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        iv;
        logic [4:0]  ird;
        logic        e_pr;
        logic        e_lr;
        logic        e_ir;
        wr_t         e_wr;
        logic [4:0]  e_bidx;
        logic        e_bval;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[18];

    function automatic vec_t mk(
        input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
        input logic iv, input logic [4:0] ird,
        input logic e_pr, input logic e_lr, input logic e_ir,
        input logic e_en, input logic [4:0] e_addr, input logic [31:0] e_data,
        input logic [4:0] e_bidx, input logic e_bval);
        vec_t v;
        v.pv = pv; v.prd = prd; v.pdata = pdata;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata;
        v.iv = iv; v.ird = ird;
        v.e_pr = e_pr; v.e_lr = e_lr; v.e_ir = e_ir;
        v.e_wr.en = e_en; v.e_wr.addr = e_addr; v.e_wr.data = e_data;
        v.e_bidx = e_bidx; v.e_bval = e_bval;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                         input logic iv, input logic [4:0] ird);
        pipe_valid = pv; pipe_rd = prd; pipe_data = pdata;
        lu_valid = lv; lu_rd = lrd; lu_data = ldata;
        issue_valid = iv; issue_rd = ird;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    // Queue the expected write result, take the edge, then compare.
    task automatic tick(input logic en, input logic [4:0] addr, input logic [31:0] data);
        wr_t e;
        wr_t w;
        e.en = en; e.addr = addr; e.data = data;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        w = exp_q.pop_front();
        chk("wr_en",   64'(wr_en),   64'(w.en));
        chk("wr_addr", 64'(wr_addr), 64'(w.addr));
        chk("wr_data", 64'(wr_data), 64'(w.data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // pv prd pdata | lv lrd ldata | iv ird | pr lr ir | en addr data | bidx bval
        tbl[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                     1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 1'b0);
        tbl[1]  = mk(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h55, 5'd0, 1'b0);
        tbl[2]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h55, 5'd0, 1'b0);
        tbl[3]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7,
                     1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h55, 5'd7, 1'b1);
        tbl[4]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7,
                     1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h55, 5'd7, 1'b1);
        tbl[5]  = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h55, 5'd7, 1'b1);
        tbl[6]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd7,
                     1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h1234, 5'd7, 1'b0);
        tbl[7]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10,
                     1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h1234, 5'd10, 1'b1);
        tbl[8]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd11,
                     1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h1234, 5'd11, 1'b1);
        tbl[9]  = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12,
                     1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h1234, 5'd12, 1'b1);
        tbl[10] = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA0, 1'b0, 5'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h1234, 5'd10, 1'b1);
        tbl[11] = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hA1, 1'b0, 5'd0,
                     1'b1, 1'b1, 1'b1, 1'b1, 5'd10, 32'hA0, 5'd10, 1'b0);
        tbl[12] = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hA2, 1'b0, 5'd0,
                     1'b1, 1'b1, 1'b1, 1'b1, 5'd11, 32'hA1, 5'd11, 1'b0);
        tbl[13] = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                     1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 32'hA2, 5'd12, 1'b0);
        tbl[14] = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'hA2, 5'd12, 1'b0);
        tbl[15] = mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h77, 1'b0, 5'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 32'hA2, 5'd0, 1'b0);
        tbl[16] = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h77, 5'd0, 1'b0);
        tbl[17] = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
                     1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h77, 5'd0, 1'b0);

        // Reset and idle.
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wr_en",       64'(wr_en),       64'd0);
        chk("rst_wr_addr",     64'(wr_addr),     64'd0);
        chk("rst_wr_data",     64'(wr_data),     64'd0);
        chk("rst_busy",        64'(busy),        64'd0);
        chk("rst_pipe_ready",  64'(pipe_ready),  64'd1);
        chk("rst_lu_ready",    64'(lu_ready),    64'd1);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);

        // Table-driven section: pipeline-only, long-latency path, back-to-back, x0 drain.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].pv, tbl[i].prd, tbl[i].pdata, tbl[i].lv, tbl[i].lrd,
                  tbl[i].ldata, tbl[i].iv, tbl[i].ird);
            #1;
            chk($sformatf("row%0d_pipe_ready", i),  64'(pipe_ready),  64'(tbl[i].e_pr));
            chk($sformatf("row%0d_lu_ready", i),    64'(lu_ready),    64'(tbl[i].e_lr));
            chk($sformatf("row%0d_issue_ready", i), 64'(issue_ready), 64'(tbl[i].e_ir));
            tick(tbl[i].e_wr.en, tbl[i].e_wr.addr, tbl[i].e_wr.data);
            chk($sformatf("row%0d_busy_bit", i), 64'(busy[tbl[i].e_bidx]), 64'(tbl[i].e_bval));
        end
        chk("table_busy_clear", 64'(busy), 64'd0);

        // Scoreboard concurrency: issue rd=3 while the buffer drains rd=4.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
        tick(1'b0, 5'd0, 32'h77);
        chk("conc_busy4_set", 64'(busy[4]), 64'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
        tick(1'b0, 5'd0, 32'h77);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        #1;
        chk("conc_issue_ready", 64'(issue_ready), 64'd1);
        tick(1'b1, 5'd4, 32'h44);
        chk("conc_busy", 64'(busy), 64'h0000_0008);

        // Contention: buffer holds rd=9 while the pipeline requests every cycle.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        tick(1'b0, 5'd4, 32'h44);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
        tick(1'b0, 5'd4, 32'h44);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd20, 32'h1000 + 32'(k), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            #1;
            chk($sformatf("starve%0d_pipe_ready", k), 64'(pipe_ready), 64'd1);
            chk($sformatf("starve%0d_lu_ready", k),   64'(lu_ready),   64'd0);
            tick(1'b1, 5'd20, 32'h1000 + 32'(k));
        end
        drive(1'b1, 5'd21, 32'hBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #1;
        chk("force_pipe_ready", 64'(pipe_ready), 64'd0);
        chk("force_lu_ready",   64'(lu_ready),   64'd1);
        tick(1'b1, 5'd9, 32'h99);
        chk("force_busy9", 64'(busy[9]), 64'd0);
        #1;
        chk("resume_pipe_ready", 64'(pipe_ready), 64'd1);
        tick(1'b1, 5'd21, 32'hBEEF);
        idle();
        tick(1'b0, 5'd21, 32'hBEEF);

        // Asynchronous reset with the buffer full and a write in flight.
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd15);
        tick(1'b0, 5'd21, 32'hBEEF);
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd15, 32'hF15, 1'b0, 5'd0);
        tick(1'b1, 5'd6, 32'h66);
        drive(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        #1;
        chk("pre_rst_lu_ready", 64'(lu_ready), 64'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en",      64'(wr_en),      64'd0);
        chk("arst_wr_addr",    64'(wr_addr),    64'd0);
        chk("arst_busy",       64'(busy),       64'd0);
        chk("arst_lu_ready",   64'(lu_ready),   64'd1);
        chk("arst_pipe_ready", 64'(pipe_ready), 64'd1);
        idle();
        #2;
        rst_n = 1'b1;
        tick(1'b0, 5'd0, 32'd0);
        chk("post_rst_busy",     64'(busy),     64'd0);
        chk("post_rst_lu_ready", 64'(lu_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
